// File: rtl/mem_access_stage.sv
// MEM stage of the 16-bit pipeline: ALU/NOP retire in one cycle, LOAD/STORE hold EX until dm_ack or timeout.
// Optional byte-lane loads/stores are enabled by defining MEM_BYTE_OPS_EN.
module mem_access_stage #(
  parameter int ARQ     = 16,
  parameter int ADDR_W  = 16,
  parameter int REG_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [1:0]        ex_op,
  input  logic              ex_byte,
  input  logic [ARQ-1:0]    ex_alu,
  input  logic [ARQ-1:0]    ex_sdata,
  input  logic [REG_W-1:0]  ex_rd,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [ARQ-1:0]    dm_wdata,
  output logic [1:0]        dm_be,
  input  logic              dm_ack,
  input  logic [ARQ-1:0]    dm_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_W-1:0]  wb_rd,
  output logic [ARQ-1:0]    wb_data,
  output logic              mem_err
);

  localparam logic [1:0] OP_ALU   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam int         CNT_W    = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt;
  logic               xfer, is_mem, ack_hit, tmo_hit;

  logic               store_p0;
  logic [ADDR_W-1:0]  addr_p0;
  logic [ARQ-1:0]     sdata_p0;
  logic [REG_W-1:0]   rd_p0;

  logic [ARQ-1:0]     wdata_c;
  logic [1:0]         be_c;
  logic [ARQ-1:0]     load_data;

  assign xfer    = ex_valid & ex_ready;
  assign is_mem  = (ex_op == OP_LOAD) || (ex_op == OP_STORE);
  assign ack_hit = (state == ACCESS) && dm_ack;
  assign tmo_hit = (state == ACCESS) && !dm_ack && (cnt == CNT_W'(TIMEOUT - 1));

`ifdef MEM_BYTE_OPS_EN
  logic byte_p0;

  function automatic logic signed [ARQ-1:0] byte_ext(input logic signed [7:0] b);
    return {{(ARQ-8){b[7]}}, b};
  endfunction

  always_comb begin
    wdata_c   = sdata_p0;
    be_c      = 2'b11;
    load_data = dm_rdata;
    if (byte_p0) begin
      wdata_c   = ARQ'({sdata_p0[7:0], sdata_p0[7:0]});
      be_c      = addr_p0[0] ? 2'b10 : 2'b01;
      load_data = byte_ext(addr_p0[0] ? dm_rdata[15:8] : dm_rdata[7:0]);
    end
  end
`else
  logic unused_byte;
  assign unused_byte = ex_byte;
  assign wdata_c     = sdata_p0;
  assign be_c        = 2'b11;
  assign load_data   = dm_rdata;
`endif

  // Stage p0: memory-op operands captured at accept, held for the whole access
  always_ff @(posedge clk) begin
    if (xfer && is_mem) begin
      store_p0 <= (ex_op == OP_STORE);
      addr_p0  <= ex_alu[ADDR_W-1:0];
      sdata_p0 <= ex_sdata;
      rd_p0    <= ex_rd;
`ifdef MEM_BYTE_OPS_EN
      byte_p0  <= ex_byte;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // Bus outputs decode from state so an async reset drops dm_req at once
  always_comb begin
    state_d  = state;
    ex_ready = 1'b0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    dm_be    = 2'b00;
    case (state)
      IDLE: begin
        ex_ready = 1'b1;
        if (xfer && is_mem) state_d = ACCESS;
      end
      ACCESS: begin
        dm_req   = 1'b1;
        dm_we    = store_p0;
        dm_addr  = addr_p0;
        dm_wdata = wdata_c;
        dm_be    = be_c;
        if (ack_hit || tmo_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  cnt <= '0;
    else if (state == IDLE)    cnt <= '0;
    else if (!dm_ack)          cnt <= cnt + CNT_W'(1);
  end

  // Stage p1: writeback registers; wb_rd/wb_data hold when nothing retires
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      mem_err  <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (xfer && !is_mem) begin
        wb_valid <= 1'b1;
        wb_rd    <= ex_rd;
        if (ex_op == OP_ALU) begin
          wb_we   <= (ex_rd != '0);
          wb_data <= ex_alu;
        end else begin
          wb_we   <= 1'b0;
          wb_data <= '0;
        end
      end else if (ack_hit) begin
        wb_valid <= 1'b1;
        wb_rd    <= rd_p0;
        wb_we    <= !store_p0 && (rd_p0 != '0);
        wb_data  <= store_p0 ? '0 : load_data;
      end else if (tmo_hit) begin
        wb_valid <= 1'b1;
        wb_rd    <= rd_p0;
        wb_we    <= 1'b0;
        wb_data  <= '0;
        mem_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: table of single-cycle ops plus hand-written memory sequences.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [1:0]  ex_op;
  logic        ex_byte;
  logic [15:0] ex_alu;
  logic [15:0] ex_sdata;
  logic [3:0]  ex_rd;
  logic        dm_req;
  logic        dm_we;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic [1:0]  dm_be;
  logic        dm_ack;
  logic [15:0] dm_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  logic        mem_err;

  int checks   = 0;
  int failures = 0;

  mem_access_stage #(.ARQ(16), .ADDR_W(16), .REG_W(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_byte(ex_byte),
    .ex_alu(ex_alu), .ex_sdata(ex_sdata), .ex_rd(ex_rd),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] alu;
    logic [3:0]  rd;
    logic        exp_we;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] alu, input logic [15:0] sdata,
                       input logic [3:0] rd, input logic bsel);
    ex_valid = 1'b1;
    ex_op    = op;
    ex_alu   = alu;
    ex_sdata = sdata;
    ex_rd    = rd;
    ex_byte  = bsel;
  endtask

  initial begin
    vecs[0] = '{2'b00, 16'h00A5, 4'd3,  1'b1, 16'h00A5};
    vecs[1] = '{2'b00, 16'h1234, 4'd3,  1'b1, 16'h1234};
    vecs[2] = '{2'b11, 16'hFFFF, 4'd5,  1'b0, 16'h0000};
    vecs[3] = '{2'b00, 16'h7777, 4'd0,  1'b0, 16'h7777};
    vecs[4] = '{2'b00, 16'h8000, 4'd15, 1'b1, 16'h8000};
    vecs[5] = '{2'b11, 16'h0001, 4'd0,  1'b0, 16'h0000};

    rst = 1'b0; ex_valid = 1'b0; ex_op = 2'b00; ex_byte = 1'b0;
    ex_alu = '0; ex_sdata = '0; ex_rd = '0; dm_ack = 1'b0; dm_rdata = '0;
    step(); step();

    // Reset state
    chk("rst_ex_ready", ex_ready, 1);
    chk("rst_dm_req",   dm_req,   0);
    chk("rst_dm_be",    dm_be,    0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data",  wb_data,  0);
    chk("rst_wb_rd",    wb_rd,    0);
    chk("rst_mem_err",  mem_err,  0);
    rst = 1'b1;
    step();

    // Back-to-back single-cycle ops
    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].op, vecs[i].alu, 16'h0, vecs[i].rd, 1'b0);
      chk($sformatf("tbl%0d_ready", i), ex_ready, 1);
      step();
      chk($sformatf("tbl%0d_valid", i), wb_valid, 1);
      chk($sformatf("tbl%0d_we", i),    wb_we,    vecs[i].exp_we);
      chk($sformatf("tbl%0d_rd", i),    wb_rd,    vecs[i].rd);
      chk($sformatf("tbl%0d_data", i),  wb_data,  vecs[i].exp_data);
    end
    ex_valid = 1'b0;
    step();
    chk("idle_no_valid", wb_valid, 0);
    chk("idle_hold_rd",  wb_rd,    4'd0);

    // dm_ack while idle is ignored
    dm_ack = 1'b1; dm_rdata = 16'hDEAD;
    step();
    dm_ack = 1'b0;
    chk("stray_ack_valid", wb_valid, 0);
    chk("stray_ack_ready", ex_ready, 1);
    chk("stray_ack_req",   dm_req,   0);

    // LOAD with ack in the third access cycle
    issue(2'b01, 16'h0040, 16'h0, 4'd7, 1'b0);
    step();
    ex_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("ld_req_c%0d", c),   dm_req,   1);
      chk($sformatf("ld_ready_c%0d", c), ex_ready, 0);
      chk($sformatf("ld_wbv_c%0d", c),   wb_valid, 0);
      if (c == 3) begin dm_ack = 1'b1; dm_rdata = 16'hBEEF; end
      step();
    end
    dm_ack = 1'b0; dm_rdata = 16'h0;
    chk("ld_addr_gone", dm_req,  0);
    chk("ld_valid",     wb_valid, 1);
    chk("ld_we",        wb_we,    1);
    chk("ld_rd",        wb_rd,    7);
    chk("ld_data",      wb_data,  16'hBEEF);
    chk("ld_ready",     ex_ready, 1);
    step();
    chk("ld_pulse_end", wb_valid, 0);
    chk("ld_data_hold", wb_data,  16'hBEEF);

    // STORE with immediate ack, then accept in the retire cycle
    issue(2'b10, 16'h0010, 16'h5A5A, 4'd2, 1'b0);
    step();
    ex_valid = 1'b0;
    chk("st_req",   dm_req,   1);
    chk("st_we",    dm_we,    1);
    chk("st_addr",  dm_addr,  16'h0010);
    chk("st_wdata", dm_wdata, 16'h5A5A);
    chk("st_be",    dm_be,    2'b11);
    dm_ack = 1'b1;
    step();
    dm_ack = 1'b0;
    chk("st_valid", wb_valid, 1);
    chk("st_wb_we", wb_we,    0);
    chk("st_data",  wb_data,  0);
    chk("st_req_off", dm_req, 0);
    chk("st_ready", ex_ready, 1);
    issue(2'b00, 16'h0BAD, 16'h0, 4'd4, 1'b0);
    step();
    ex_valid = 1'b0;
    chk("post_st_alu_valid", wb_valid, 1);
    chk("post_st_alu_data",  wb_data,  16'h0BAD);

    // Ack arriving on the last allowed cycle completes normally
    issue(2'b01, 16'h0200, 16'h0, 4'd9, 1'b0);
    step();
    ex_valid = 1'b0;
    for (int c = 1; c < 15; c++) step();
    chk("late_ack_req", dm_req, 1);
    dm_ack = 1'b1; dm_rdata = 16'h1357;
    step();
    dm_ack = 1'b0;
    chk("late_ack_valid", wb_valid, 1);
    chk("late_ack_we",    wb_we,    1);
    chk("late_ack_data",  wb_data,  16'h1357);
    chk("late_ack_err",   mem_err,  0);

    // Timeout: dm_ack never comes
    begin
      int n;
      issue(2'b01, 16'h0100, 16'h0, 4'd6, 1'b0);
      step();
      ex_valid = 1'b0;
      n = 0;
      while (dm_req && n < 40) begin
        n++;
        step();
      end
      chk("tmo_req_cycles", n, 15);
      chk("tmo_valid", wb_valid, 1);
      chk("tmo_we",    wb_we,    0);
      chk("tmo_data",  wb_data,  0);
      chk("tmo_rd",    wb_rd,    6);
      chk("tmo_err",   mem_err,  1);
      chk("tmo_ready", ex_ready, 1);
      issue(2'b00, 16'h4321, 16'h0, 4'd1, 1'b0);
      step();
      ex_valid = 1'b0;
      chk("tmo_next_alu", wb_data, 16'h4321);
      chk("tmo_err_sticky", mem_err, 1);
    end

    // Reset mid-access
    issue(2'b01, 16'h0300, 16'h0, 4'd8, 1'b0);
    step();
    ex_valid = 1'b0;
    step();
    chk("mid_req_before", dm_req, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_req",   dm_req,   0);
    chk("mid_rst_ready", ex_ready, 1);
    chk("mid_rst_err",   mem_err,  0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("mid_rst_no_wb", wb_valid, 0);
    chk("mid_rst_idle",  dm_req,   0);

`ifdef MEM_BYTE_OPS_EN
    // Byte lanes
    issue(2'b01, 16'h0021, 16'h0, 4'd3, 1'b1);
    step();
    ex_valid = 1'b0;
    dm_ack = 1'b1; dm_rdata = 16'h80FF;
    step();
    dm_ack = 1'b0;
    chk("bld_data", wb_data, 16'hFF80);
    issue(2'b10, 16'h0020, 16'h0037, 4'd3, 1'b1);
    step();
    ex_valid = 1'b0;
    chk("bst_wdata", dm_wdata, 16'h3737);
    chk("bst_be",    dm_be,    2'b01);
    dm_ack = 1'b1;
    step();
    dm_ack = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
